// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: access sizes, FSM states,
// default DM base address and small decode helpers.
package dm_pkg;

    // Access size encodings as seen on the requester size ports
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Default byte address of DM word 0
    localparam logic [31:0] DM_BASE_ADDR = 32'h6600_0000;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_RD = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Right-aligned data mask for an access size; the illegal size masks everything
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] mask;
        case (size)
            SZ_B:    mask = 32'h0000_00FF;
            SZ_H:    mask = 32'h0000_FFFF;
            SZ_W:    mask = 32'hFFFF_FFFF;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

    // True when the size is illegal or the byte offset is not aligned to it
    function automatic logic bad_alignment(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offset[0];
            SZ_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering for the word-wide DM: pulls a right-aligned, zero-extended
// value out of a read word for loads, and merges right-aligned store data into
// the addressed lane(s) of an existing word for sub-word stores.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_word
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_lane_mask;

    // Shift by whole bytes: extract for loads, replace only the addressed lanes for stores
    always_comb begin
        w_shift      = {i_offset, 3'b000};
        w_mask       = size_mask(i_size);
        w_lane_mask  = w_mask << w_shift;
        o_load_data  = (i_rd_word >> w_shift) & w_mask;
        o_merge_word = (i_old_word & ~w_lane_mask) | ((i_wdata << w_shift) & w_lane_mask);
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, word-wide data memory.
// Port 0 is the core load/store unit, port 1 the debug/DMA master. Each accepted
// request is range/alignment checked, then sequenced as a load, a word store or a
// read-modify-write sub-word store, and answered with a one-cycle response pulse.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR,
    parameter int unsigned DEPTH_BYTES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_size_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_size_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wd_o,
    output logic        dm_we_o,
    input  logic [31:0] dm_rd_i
);

    localparam logic [32:0] LP_DEPTH = 33'(DEPTH_BYTES);

    state_t      r_state;
    state_t      w_next_state;

    // r_last is the port granted most recently; m0 wins a tie when it is 1
    logic        r_last;
    logic        r_port;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rmw_word;
    logic [31:0] r_rdata;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_sel_err;
    logic        w_in_access;
    logic        w_resp;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_word;

    // Round-robin grant, offered only while idle and out of reset
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == ST_IDLE && rst_n_i) begin
            if (m0_req_i && (!m1_req_i || r_last)) begin
                w_gnt0 = 1'b1;
            end else if (m1_req_i) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // Select the winner's request fields and decide whether it must be rejected
    always_comb begin
        w_any_gnt   = w_gnt0 | w_gnt1;
        w_sel_we    = w_gnt1 ? m1_we_i    : m0_we_i;
        w_sel_size  = w_gnt1 ? m1_size_i  : m0_size_i;
        w_sel_addr  = w_gnt1 ? m1_addr_i  : m0_addr_i;
        w_sel_wdata = w_gnt1 ? m1_wdata_i : m0_wdata_i;
        w_offset    = w_sel_addr - BASE_ADDR;
        w_in_range  = (w_sel_addr >= BASE_ADDR) && ({1'b0, w_offset} < LP_DEPTH);
        w_sel_err   = bad_alignment(w_sel_size, w_sel_addr[1:0]) || !w_in_range;
    end

    // Next-state: errors answer at once, sub-word stores read the word first
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_gnt) begin
                    if (w_sel_err) begin
                        w_next_state = ST_RESP;
                    end else if (w_sel_we && w_sel_size != SZ_W) begin
                        w_next_state = ST_RMW_RD;
                    end else begin
                        w_next_state = ST_ACCESS;
                    end
                end
            end
            ST_RMW_RD: w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and latched transaction; reset drops any request in flight
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rmw_word <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_gnt) begin
                        r_last  <= w_gnt1;
                        r_port  <= w_gnt1;
                        r_we    <= w_sel_we;
                        r_size  <= w_sel_size;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_err   <= w_sel_err;
                        r_rdata <= '0;
                    end
                end
                ST_RMW_RD: r_rmw_word <= dm_rd_i;
                ST_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    dm_lane_unit u_lane (
        .i_offset     (r_addr[1:0]),
        .i_size       (r_size),
        .i_rd_word    (dm_rd_i),
        .i_old_word   (r_rmw_word),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    // DM drive: address during the read and access phases, writes only for stores in ACCESS
    always_comb begin
        w_in_access = (r_state == ST_ACCESS);
        dm_addr_o   = '0;
        dm_wd_o     = '0;
        dm_we_o     = 1'b0;
        if (rst_n_i && (r_state == ST_RMW_RD || w_in_access)) begin
            dm_addr_o = {r_addr[31:2], 2'b00};
        end
        if (rst_n_i && w_in_access && r_we) begin
            dm_we_o = 1'b1;
            dm_wd_o = (r_size == SZ_W) ? r_wdata : w_merge_word;
        end
    end

    // Grant pulses and the one-cycle response steered to the latched port
    always_comb begin
        w_resp      = rst_n_i && (r_state == ST_RESP);
        m0_gnt_o    = w_gnt0;
        m1_gnt_o    = w_gnt1;
        m0_rvalid_o = w_resp && !r_port;
        m1_rvalid_o = w_resp && r_port;
        m0_rdata_o  = m0_rvalid_o ? r_rdata : '0;
        m1_rdata_o  = m1_rvalid_o ? r_rdata : '0;
        m0_err_o    = m0_rvalid_o && r_err;
        m1_err_o    = m1_rvalid_o && r_err;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a table of single transactions with a
// response scoreboard, plus hand-written round-robin and mid-RMW reset sequences.
module tb_dm_arbiter;
    import dm_pkg::*;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        bit          expErr;
        int          expLat;
        int          expWe;
        logic [31:0] expWd;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
    logic [1:0]  m0_size_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
    logic [1:0]  m1_size_i;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [31:0] dm_addr_o, dm_wd_o, dm_rd_i;
    logic        dm_we_o;

    logic [31:0] mem [0:1023];
    logic        memClear;
    int          weTotal = 0;
    int          rvTotal = 0;
    logic [31:0] lastWd = '0;
    int          assertCount = 0;
    int          failCount = 0;
    resp_t       sb[$];
    vec_t        vecs[15];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .m0_req_i    (m0_req_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_we_i     (m0_we_i),
        .m0_size_i   (m0_size_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m0_err_o    (m0_err_o),
        .m1_req_i    (m1_req_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_we_i     (m1_we_i),
        .m1_size_i   (m1_size_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .m1_err_o    (m1_err_o),
        .dm_addr_o   (dm_addr_o),
        .dm_wd_o     (dm_wd_o),
        .dm_we_o     (dm_we_o),
        .dm_rd_i     (dm_rd_i)
    );

    // Behavioural DM: combinational read, write on the rising edge
    assign dm_rd_i = mem[dm_addr_o[11:2]];

    // DM storage, cleared by the bench before the first access
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (dm_we_o) begin
            mem[dm_addr_o[11:2]] <= dm_wd_o;
        end
    end

    // Monitor: counts DM writes and response pulses away from the clock edge
    always @(negedge clk) begin
        if (dm_we_o) begin
            weTotal = weTotal + 1;
            lastWd  = dm_wd_o;
        end
        if (m0_rvalid_o || m1_rvalid_o) rvTotal = rvTotal + 1;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drivePort(input bit port, input bit req, input bit we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            m1_req_i = req; m1_we_i = we; m1_size_i = size; m1_addr_i = addr; m1_wdata_i = wdata;
        end else begin
            m0_req_i = req; m0_we_i = we; m0_size_i = size; m0_addr_i = addr; m0_wdata_i = wdata;
        end
    endtask

    // Request on one port, wait (bounded) for its grant, push the expected response
    task automatic applyStimulus(input vec_t v, output bit granted);
        resp_t r;
        granted = 1'b0;
        drivePort(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
        for (int c = 0; c < 50 && !granted; c++) begin
            @(negedge clk);
            if ((v.port ? m1_gnt_o : m0_gnt_o) == 1'b1) granted = 1'b1;
        end
        if (!granted) begin
            compare("grant timeout", 32'd0, 32'd1);
        end else begin
            r.port = v.port; r.rdata = v.expRdata; r.err = v.expErr; r.lat = v.expLat;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        drivePort(v.port, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    // Wait (bounded) for the response after a grant edge and compare against the scoreboard
    task automatic checkOutput();
        resp_t r;
        int    lat = 0;
        bit    seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (m0_rvalid_o || m1_rvalid_o) seen = 1'b1;
        end
        if (!seen) begin
            compare("rvalid timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            compare("unexpected response", 32'd1, 32'd0);
            return;
        end
        r = sb.pop_front();
        compare("rvalid port", {30'd0, m1_rvalid_o, m0_rvalid_o}, r.port ? 32'd2 : 32'd1);
        compare("rdata", r.port ? m1_rdata_o : m0_rdata_o, r.rdata);
        compare("err", {31'd0, r.port ? m1_err_o : m0_err_o}, {31'd0, r.err});
        compare("latency", lat, r.lat);
    endtask

    task automatic runVector(input vec_t v);
        int weBefore;
        bit granted;
        weBefore = weTotal;
        applyStimulus(v, granted);
        if (granted) begin
            checkOutput();
            compare("dm write count", weTotal - weBefore, v.expWe);
            if (v.expWe > 0) compare("dm write data", lastWd, v.expWd);
        end
    endtask

    task automatic resetDut();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
    endtask

    initial begin
        vec_t        v;
        resp_t       r;
        int          weBefore, rvBefore;
        bit          granted, seen, gp;

        // port, we, size, addr, wdata, expRdata, expErr, expLat, expWe, expWd
        vecs[0]  = '{1'b0, 1'b1, SZ_W,  32'h6600_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 1'b0, SZ_W,  32'h6600_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, SZ_B,  32'h6600_0006, 32'hAAAA_AA55, 32'h0,         1'b0, 3, 1, 32'hDE55_BEEF};
        vecs[3]  = '{1'b0, 1'b0, SZ_B,  32'h6600_0006, 32'h0,         32'h0000_0055, 1'b0, 2, 0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, SZ_H,  32'h6600_0006, 32'h0,         32'h0000_DE55, 1'b0, 2, 0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, SZ_W,  32'h6600_1000, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, SZ_W,  32'h6600_0003, 32'h1111_1111, 32'h0,         1'b1, 1, 0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 2'b11, 32'h6600_0004, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, SZ_H,  32'h6600_0004, 32'hFFFF_1234, 32'h0,         1'b0, 3, 1, 32'hDE55_1234};
        vecs[9]  = '{1'b1, 1'b0, SZ_W,  32'h6600_0004, 32'h0,         32'hDE55_1234, 1'b0, 2, 0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, SZ_H,  32'h6600_0001, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, SZ_W,  32'h65FF_FFFC, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0};
        vecs[12] = '{1'b0, 1'b1, SZ_W,  32'h6600_0FFC, 32'h1122_3344, 32'h0,         1'b0, 2, 1, 32'h1122_3344};
        vecs[13] = '{1'b0, 1'b0, SZ_B,  32'h6600_0FFF, 32'h0,         32'h0000_0011, 1'b0, 2, 0, 32'h0};
        vecs[14] = '{1'b1, 1'b1, SZ_W,  32'h6600_0008, 32'h0BAD_F00D, 32'h0,         1'b0, 2, 1, 32'h0BAD_F00D};

        memClear = 1'b1;
        rst_n_i  = 1'b0;
        drivePort(1'b0, 1'b1, 1'b0, SZ_W, 32'h6600_0004, 32'h0);
        drivePort(1'b1, 1'b1, 1'b0, SZ_W, 32'h6600_0008, 32'h0);
        repeat (2) @(posedge clk);
        #1 memClear = 1'b0;

        // Reset state: requests pending but nothing granted or driven
        @(negedge clk);
        compare("reset gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
        compare("reset rvalid/err", {28'd0, m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}, 32'd0);
        compare("reset rdata", m0_rdata_o | m1_rdata_o, 32'd0);
        compare("reset dm_addr", dm_addr_o, 32'd0);
        compare("reset dm_wd/we", dm_wd_o | {31'd0, dm_we_o}, 32'd0);
        drivePort(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drivePort(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst_n_i = 1'b1;

        $display("[TB] table-driven transactions");
        for (int i = 0; i < 15; i++) runVector(vecs[i]);

        $display("[TB] round-robin with both ports requesting");
        resetDut();
        drivePort(1'b0, 1'b1, 1'b0, SZ_W, 32'h6600_0004, 32'h0);
        drivePort(1'b1, 1'b1, 1'b0, SZ_W, 32'h6600_0008, 32'h0);
        for (int g = 0; g < 4; g++) begin
            granted = 1'b0;
            gp = 1'b0;
            for (int c = 0; c < 20 && !granted; c++) begin
                @(negedge clk);
                if (m0_gnt_o || m1_gnt_o) begin
                    granted = 1'b1;
                    gp = m1_gnt_o;
                end
            end
            if (!granted) begin
                compare("rr grant timeout", 32'd0, 32'd1);
                break;
            end
            compare("rr grant order", {31'd0, gp}, (g % 2 == 1) ? 32'd1 : 32'd0);
            r.port  = gp;
            r.rdata = gp ? 32'h0BAD_F00D : 32'hDE55_1234;
            r.err   = 1'b0;
            r.lat   = 2;
            sb.push_back(r);
            @(posedge clk);
            #1;
            if (g == 3) begin
                m0_req_i = 1'b0;
                m1_req_i = 1'b0;
            end
            checkOutput();
        end
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;

        $display("[TB] reset during RMW read phase");
        repeat (2) @(posedge clk);
        #1;
        weBefore = weTotal;
        rvBefore = rvTotal;
        drivePort(1'b0, 1'b1, 1'b1, SZ_B, 32'h6600_0004, 32'h0000_0077);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (m0_gnt_o) seen = 1'b1;
        end
        compare("rmw store grant", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rst_n_i  = 1'b0;
        m0_req_i = 1'b0;
        @(negedge clk);
        compare("dm_we in reset", {31'd0, dm_we_o}, 32'd0);
        @(posedge clk);
        #1 rst_n_i = 1'b1;
        v = '{1'b1, 1'b0, SZ_W, 32'h6600_0008, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 0, 32'h0};
        applyStimulus(v, granted);
        compare("grant right after reset", {31'd0, granted}, 32'd1);
        if (granted) checkOutput();
        repeat (3) @(negedge clk);
        compare("writes after dropped rmw", weTotal - weBefore, 32'd0);
        compare("responses after dropped rmw", rvTotal - rvBefore, 32'd1);
        compare("memory word kept", mem[1], 32'hDE55_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences and shares the single-port data memory (DM) between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA master.
- Performs round-robin arbitration and address range and alignment checking.
- Implements byte and halfword stores as read-modify-write on the word-wide DM.
- Sits between the requesters and DM. DM has a combinational read (`rd`) and a write on the clock edge when `we` is high.

Parameters:
- BASE_ADDR, 32'h66000000, byte address of DM word 0.
- DEPTH_BYTES, 4096, DM size in bytes (power of 2, at least 4).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset; one clock; synchronous, active-low.
- m0_req_i, m1_req_i  in  1  request; held with its fields stable until the matching gnt.
- m0_gnt_o, m1_gnt_o  out  1  grant; request accepted on this edge.
- m0_we_i, m1_we_i  in  1  1 = store, 0 = load.
- m0_size_i, m1_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- m0_addr_i, m1_addr_i  in  32  byte address.
- m0_wdata_i, m1_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- m0_rvalid_o, m1_rvalid_o  out  1  one-cycle response pulse; sent for loads and stores.
- m0_rdata_o, m1_rdata_o  out  32  load data, zero-extended and right-aligned; 0 for stores and errors.
- m0_err_o, m1_err_o  out  1  qualifies rvalid; access was rejected.
- dm_addr_o  out  32  word-aligned DM address (request address with [1:0] = 0).
- dm_wd_o  out  32  DM write data.
- dm_we_o  out  1  DM write enable.
- dm_rd_i  in  32  DM read data (combinational).

Behaviour:
- FSM states: IDLE, RMW_RD, ACCESS, RESP.
- Reset:
  - State goes to IDLE and the round-robin pointer is set so m0 wins the first tie.
  - All gnt, rvalid, err and rdata outputs are 0; dm_addr_o and dm_wd_o are 0.
  - dm_we_o is gated with rst_n_i: no DM write happens in a cycle where rst_n_i = 0, even mid-RMW.
  - Any in-flight request is dropped with no response.
- IDLE arbitration:
  - Only one requester: it is granted.
  - Both requesting: grant goes to the port not granted last.
  - gnt_o is a combinational pulse in IDLE only, at most one high.
  - On the grant edge, port id, we, size, addr and wdata are latched.
- Error check at the grant edge. An error is any of:
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr < BASE_ADDR, or addr >= BASE_ADDR + DEPTH_BYTES.
- Error path: IDLE -> RESP, with err = 1, rdata = 0, no DM access.
- Load or word store: IDLE -> ACCESS -> RESP.
  - Load ACCESS: captures dm_rd_i shifted right by 8*addr[1:0], masked to size.
  - Word-store ACCESS: dm_we_o = 1 and dm_wd_o = wdata.
- Sub-word store: IDLE -> RMW_RD -> ACCESS -> RESP.
  - RMW_RD captures dm_rd_i.
  - ACCESS writes the captured word with the addressed lane(s) replaced by wdata, with dm_we_o = 1.
- dm_addr_o is valid in RMW_RD and ACCESS; dm_we_o is high only in ACCESS for stores.
- RESP:
  - rvalid_o = 1 for exactly one cycle on the latched port only, with rdata/err.
  - Then returns to IDLE. A new grant is possible in the cycle after RESP.
- Latency from grant edge to rvalid: 2 cycles for load or word store, 3 for sub-word store, 1 for error.
- A request that arrives while busy waits; req must stay high until gnt.
- The round-robin pointer updates on every grant, including error grants.

Decomposition:
- Shared package dm_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W;
  - FSM state encodings;
  - the BASE_ADDR default.
- Natural sub-module: dm_lane_unit (combinational), which does lane extract for loads and lane merge for stores from addr[1:0], size and data.
- The arbiter and FSM stay in dm_arbiter.

Test Plan:
- m0 word store 0x66000004 <- 0xDEADBEEF, then load word -> dm_we_o high for 1 cycle in ACCESS; load rvalid at grant+2 with rdata = 0xDEADBEEF, err = 0.
- m0 byte store 0x66000006 <- 0x55 over 0xDEADBEEF -> RMW: dm_we_o high once with dm_wd_o = 0xDE55BEEF; byte load 0x66000006 returns 0x00000055; half load 0x66000006 returns 0x0000DE55.
- m0 and m1 both request continuously -> grants alternate m0, m1, m0, m1; each rvalid appears only on the granted port.
- Error cases, each with a single rvalid at grant+1, err = 1, and dm_we_o never high:
  - load 0x66001000 (out of range);
  - word store 0x66000003 (misaligned);
  - size = 11.
- rst_n_i = 0 asserted in the RMW_RD cycle of a byte store -> no DM write, no rvalid, FSM in IDLE next cycle, memory word unchanged.
